// File: rtl/fpu_zc_pkg.sv
// Shared types and helpers for the FPU zero counter.
package fpu_zc_pkg;

  typedef enum logic {
    ZC_TRAILING = 1'b0,
    ZC_LEADING  = 1'b1
  } zc_mode_e;

  function automatic int unsigned num_chunks(input int unsigned data_width,
                                             input int unsigned chunk_width);
    return (data_width + chunk_width - 1) / chunk_width;
  endfunction

endpackage

// File: rtl/zc_chunk_counter.sv
// Combinational zero count for one chunk.
// Leading mode counts down from the chunk MSB. Trailing mode counts up from the chunk LSB.
module zc_chunk_counter
  import fpu_zc_pkg::*;
#(
  parameter  int unsigned Width = 8,
  localparam int unsigned CntW  = $clog2(Width + 1)
) (
  input  logic [Width-1:0] data_i,
  input  zc_mode_e         mode_i,
  output logic [CntW-1:0]  cnt_o,
  output logic             zero_o
);

  logic [Width-1:0] scan;
  logic             found;

  always_comb begin
    scan  = data_i;
    if (mode_i == ZC_LEADING) scan = {<<{data_i}};
    cnt_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < Width; i++) begin
      if (!found) begin
        if (scan[i]) found = 1'b1;
        else         cnt_o = cnt_o + CntW'(1);
      end
    end
    zero_o = ~|data_i;
  end

endmodule

// File: rtl/pipelined_zero_counter.sv
// Two-stage leading/trailing zero counter with valid/ready handshake.
// Optional macro ZC_NORMALIZE_EN adds out_norm, which is the operand shifted by the count.
module pipelined_zero_counter
  import fpu_zc_pkg::*;
#(
  parameter  int unsigned DataWidth  = 25,
  parameter  int unsigned ChunkWidth = 8,
  localparam int unsigned CntWidth   = $clog2(DataWidth + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DataWidth-1:0] in_data,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CntWidth-1:0]  out_count,
  output logic                 out_zero,
`ifdef ZC_NORMALIZE_EN
  output logic [DataWidth-1:0] out_norm,
`endif
  output logic                 out_mode
);

  localparam int unsigned NumChunks = num_chunks(DataWidth, ChunkWidth);
  localparam int unsigned ChunkCntW = $clog2(ChunkWidth + 1);

  typedef struct packed {
    logic [NumChunks-1:0][ChunkCntW-1:0] cnt;
    logic [NumChunks-1:0]                zero;
    zc_mode_e                            mode;
`ifdef ZC_NORMALIZE_EN
    logic [DataWidth-1:0]                data;
`endif
  } s1_t;

  logic [NumChunks-1:0][ChunkCntW-1:0] chunk_cnt;
  logic [NumChunks-1:0]                chunk_zero;
  s1_t                                 s1_d, s1_q;
  logic                                s1_valid_q, s2_valid_q;
  logic                                s1_adv, s2_adv;
  logic [CntWidth-1:0]                 count_d, count_q;
  logic                                zero_d, zero_q;
  zc_mode_e                            mode_q;
  logic                                stop;
  int unsigned                         idx;
`ifdef ZC_NORMALIZE_EN
  logic [DataWidth-1:0]                norm_d, norm_q;
`endif

  // The top chunk is narrowed to the bits that remain, so pad bits never exist.
  for (genvar g = 0; g < NumChunks; g++) begin : g_chunk
    localparam int unsigned Lo  = g * ChunkWidth;
    localparam int unsigned Wid = (Lo + ChunkWidth > DataWidth) ? DataWidth - Lo : ChunkWidth;
    logic [$clog2(Wid+1)-1:0] cnt;

    zc_chunk_counter #(.Width(Wid)) u_chunk (
      .data_i (in_data[Lo +: Wid]),
      .mode_i (zc_mode_e'(in_mode)),
      .cnt_o  (cnt),
      .zero_o (chunk_zero[g])
    );
    assign chunk_cnt[g] = ChunkCntW'(cnt);
  end

  always_comb begin
    s1_d      = '0;
    s1_d.cnt  = chunk_cnt;
    s1_d.zero = chunk_zero;
    s1_d.mode = zc_mode_e'(in_mode);
`ifdef ZC_NORMALIZE_EN
    s1_d.data = in_data;
`endif
  end

  // Add whole zero chunks in scan order, then stop after the first non-zero chunk.
  always_comb begin
    count_d = '0;
    stop    = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NumChunks; k++) begin
      idx = (s1_q.mode == ZC_LEADING) ? NumChunks - 1 - k : k;
      if (!stop) begin
        count_d = count_d + CntWidth'(s1_q.cnt[idx]);
        stop    = !s1_q.zero[idx];
      end
    end
    zero_d = &s1_q.zero;
`ifdef ZC_NORMALIZE_EN
    norm_d = (s1_q.mode == ZC_LEADING) ? s1_q.data << count_d : s1_q.data >> count_d;
`endif
  end

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      count_q    <= '0;
      zero_q     <= 1'b0;
      mode_q     <= ZC_TRAILING;
`ifdef ZC_NORMALIZE_EN
      norm_q     <= '0;
`endif
    end else begin
      if (s1_adv)             s1_valid_q <= in_valid;
      if (s1_adv && in_valid) s1_q       <= s1_d;
      if (s2_adv)             s2_valid_q <= s1_valid_q;
      if (s2_adv && s1_valid_q) begin
        count_q <= count_d;
        zero_q  <= zero_d;
        mode_q  <= s1_q.mode;
`ifdef ZC_NORMALIZE_EN
        norm_q  <= norm_d;
`endif
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_count = count_q;
  assign out_zero  = zero_q;
  assign out_mode  = mode_q;
`ifdef ZC_NORMALIZE_EN
  assign out_norm  = norm_q;
`endif

endmodule

// File: tb/tb_pipelined_zero_counter.sv
// Self-checking bench for pipelined_zero_counter across ChunkWidth 1, 5, 8 and 25.
// It uses a queue-based reference model. Define ZC_NORMALIZE_EN to also check out_norm.
module tb_pipelined_zero_counter;

  localparam int unsigned DW   = 25;
  localparam int unsigned CNTW = 5;
  localparam int unsigned NDUT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_mode = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic            ir [NDUT];
  logic            ov [NDUT];
  logic            oz [NDUT];
  logic            om [NDUT];
  logic [CNTW-1:0] oc [NDUT];
`ifdef ZC_NORMALIZE_EN
  logic [DW-1:0]   onorm [NDUT];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned CW = (g == 0) ? 1 : (g == 1) ? 5 : (g == 2) ? 8 : 25;
    pipelined_zero_counter #(.DataWidth(DW), .ChunkWidth(CW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (ir[g]),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .out_count (oc[g]),
      .out_zero  (oz[g]),
`ifdef ZC_NORMALIZE_EN
      .out_norm  (onorm[g]),
`endif
      .out_mode  (om[g])
    );
  end

  typedef struct {
    logic [DW-1:0]   data;
    logic            mode;
    logic [CNTW-1:0] cnt;
    logic            zero;
    logic [DW-1:0]   norm;
    int              cyc;
  } txn_t;

  typedef struct {
    logic [DW-1:0]   data;
    logic            mode;
    logic [CNTW-1:0] cnt;
    logic            zero;
    logic [DW-1:0]   norm;
  } vec_t;

  txn_t q[$];
  vec_t vecs[13];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  task automatic check(input string name, input int unsigned dut,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, dut, $time, act, exp);
    end
  endtask

  function automatic txn_t ref_model(input logic [DW-1:0] d, input logic m);
    txn_t t;
    int   n = 0;
    for (int i = 0; i < int'(DW); i++) begin
      if ((m ? d[int'(DW)-1-i] : d[i]) == 1'b1) break;
      n++;
    end
    t.data = d;
    t.mode = m;
    t.cnt  = CNTW'(n);
    t.zero = (d == '0);
    t.norm = (d == '0) ? '0 : (m ? d << n : d >> n);
    t.cyc  = 0;
    return t;
  endfunction

  // Sample after the inputs settle. Compare against the model and advance the model.
  // Then move on to the next falling edge.
  task automatic eval();
    logic exp_ov, exp_ir;
    txn_t t;
    #1;
    exp_ov = (q.size() > 0) && (cyc >= q[0].cyc + 2);
    exp_ir = out_ready || (q.size() < 2);
    for (int unsigned i = 0; i < NDUT; i++) begin
      check("in_ready", i, 32'(ir[i]), 32'(exp_ir));
      check("out_valid", i, 32'(ov[i]), 32'(exp_ov));
      if (exp_ov) begin
        check("out_count", i, 32'(oc[i]), 32'(q[0].cnt));
        check("out_zero", i, 32'(oz[i]), 32'(q[0].zero));
        check("out_mode", i, 32'(om[i]), 32'(q[0].mode));
`ifdef ZC_NORMALIZE_EN
        check("out_norm", i, 32'(onorm[i]), 32'(q[0].norm));
`endif
      end
    end
    if (exp_ov && out_ready) t = q.pop_front();
    if (in_valid && exp_ir) begin
      t = ref_model(in_data, in_mode);
      t.cyc = cyc;
      q.push_back(t);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic m, input logic [DW-1:0] d);
    in_valid = v;
    in_mode  = m;
    in_data  = d;
    eval();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    vecs[0]  = '{25'h0000008, 1'b0, 5'd3,  1'b0, 25'h0000001};
    vecs[1]  = '{25'h0100000, 1'b1, 5'd4,  1'b0, 25'h1000000};
    vecs[2]  = '{25'h0100000, 1'b0, 5'd20, 1'b0, 25'h0000001};
    vecs[3]  = '{25'h1FFFFFF, 1'b0, 5'd0,  1'b0, 25'h1FFFFFF};
    vecs[4]  = '{25'h1FFFFFF, 1'b1, 5'd0,  1'b0, 25'h1FFFFFF};
    vecs[5]  = '{25'h0000000, 1'b0, 5'd25, 1'b1, 25'h0000000};
    vecs[6]  = '{25'h0000000, 1'b1, 5'd25, 1'b1, 25'h0000000};
    vecs[7]  = '{25'h1000000, 1'b0, 5'd24, 1'b0, 25'h0000001};
    vecs[8]  = '{25'h1000000, 1'b1, 5'd0,  1'b0, 25'h1000000};
    vecs[9]  = '{25'h0000001, 1'b1, 5'd24, 1'b0, 25'h1000000};
    vecs[10] = '{25'h0000100, 1'b0, 5'd8,  1'b0, 25'h0000001};
    vecs[11] = '{25'h0000080, 1'b1, 5'd17, 1'b0, 25'h1000000};
    vecs[12] = '{25'h0000001, 1'b0, 5'd0,  1'b0, 25'h0000001};

    #2;
    for (int unsigned i = 0; i < NDUT; i++) begin
      check("reset_valid", i, 32'(ov[i]), 32'd0);
      check("reset_count", i, 32'(oc[i]), 32'd0);
      check("reset_zero", i, 32'(oz[i]), 32'd0);
      check("reset_mode", i, 32'(om[i]), 32'd0);
`ifdef ZC_NORMALIZE_EN
      check("reset_norm", i, 32'(onorm[i]), 32'd0);
`endif
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Directed vectors. Each result is compared against the table two cycles after it is offered.
    for (int v = 0; v < 13; v++) begin
      drive(1'b1, vecs[v].mode, vecs[v].data);
      drive(1'b0, 1'($urandom), DW'($urandom));
      in_valid = 1'b0;
      #1;
      for (int unsigned i = 0; i < NDUT; i++) begin
        check("vec_valid", i, 32'(ov[i]), 32'd1);
        check("vec_count", i, 32'(oc[i]), 32'(vecs[v].cnt));
        check("vec_zero", i, 32'(oz[i]), 32'(vecs[v].zero));
`ifdef ZC_NORMALIZE_EN
        check("vec_norm", i, 32'(onorm[i]), 32'(vecs[v].norm));
`endif
      end
      drive(1'b0, 1'($urandom), DW'($urandom));
    end

    // Backpressure: three inputs are offered while the output is stalled.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_mode  = 1'(k);
      in_data  = (k == 0) ? 25'h0000010 : (k == 1) ? 25'h0004000 : 25'h0000002;
      #1;
      for (int unsigned i = 0; i < NDUT; i++)
        check("bp_in_ready", i, 32'(ir[i]), (k < 2) ? 32'd1 : 32'd0);
      in_mode = (k >= 2) ? 1'b0 : 1'(k);
      eval();
    end
    out_ready = 1'b1;
    while (in_valid) begin
      eval();
      in_valid = 1'b0;
    end
    for (int k = 0; k < 6; k++) drive(1'b0, 1'b0, '0);

    // Reset while two transactions are still in flight.
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 25'h0000400);
    drive(1'b1, 1'b0, 25'h0000400);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int unsigned i = 0; i < NDUT; i++) check("rst_mid_valid", i, 32'(ov[i]), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 25'h0000008);
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);

    // Random traffic with random backpressure.
    for (int n = 0; n < 10000; n++) begin
      case ($urandom_range(0, 3))
        0:       d = ($urandom_range(0, 3) == 0) ? '0 : DW'(1) << $urandom_range(0, DW - 1);
        1:       d = DW'($urandom);
        2:       d = DW'($urandom) >> $urandom_range(0, DW - 1);
        default: d = DW'($urandom) << $urandom_range(0, DW - 1);
      endcase
      out_ready = ($urandom_range(0, 99) < 60);
      drive($urandom_range(0, 99) < 70, 1'($urandom), d);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) drive(1'b0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_zero_counter.md
Name: pipelined_zero_counter

Overview:
Parametrised two-stage pipelined zero counter for the FPU datapath. It counts leading or trailing zeros, selected per transaction, on a mantissa-width operand. A valid/ready handshake carries transactions, with full backpressure. It serves both the normalisation after add/sub (leading) and the exactness/rounding checks (trailing), replacing per-use combinational counters.

Parameters:
DataWidth, 25, operand width (SizeMantissa 23 + 2)
ChunkWidth, 8, stage-1 chunk width; 1 <= ChunkWidth <= DataWidth
CntWidth, $clog2(DataWidth+1), count width; derived, not overridden

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept
in_data  in  DataWidth  operand
in_mode  in  1  0 = trailing zeros, 1 = leading zeros
out_valid  out  1  result valid
out_ready  in  1  consumer accepts
out_count  out  CntWidth  zero count
out_zero  out  1  operand was all zeros
out_mode  out  1  echo of in_mode

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low. Assertion immediately clears both stage valid bits and all outputs.
- Reset values: out_valid=0, out_count=0, out_zero=0, out_mode=0, out_norm=0 (if present). in_ready=1 once reset is released.
- Transfer rules: input transfers when in_valid&&in_ready; output transfers when out_valid&&out_ready.
- Latency: 2 cycles, accepted at edge N, out_valid at edge N+2. Throughput is 1 per cycle with no bubbles while out_ready=1.
- Stage 1, registered: operand split into ceil(DataWidth/ChunkWidth) chunks, chunk 0 = LSBs. Per chunk, register the directional zero count and an all-zero flag. Mode and operand are also registered (operand needed only with the optional feature).
- Stage 2, registered: priority-combine the chunks.
  - Trailing: scan from chunk 0 up.
  - Leading: scan from the top chunk down.
  - Count = sum of whole all-zero chunks + count in the first non-zero chunk.
- Partial top chunk: pad bits are never counted. The result must be identical for any legal ChunkWidth.
- All-zero operand: out_count=DataWidth, out_zero=1 in both modes. Otherwise out_zero=0.
- Handshake:
  - stage2 advances when !s2_valid || out_ready.
  - stage1 advances when !s1_valid || stage2 advances.
  - in_ready = stage1 advances (combinational from out_ready, no combinational path from in_valid).
- Stall: while out_valid && !out_ready, out_* hold stable. Up to 2 transactions are buffered, order preserved, none dropped or duplicated.
- Simultaneous accept and deliver: the pipeline fills and drains in the same cycle without a bubble.
- in_data/in_mode are ignored when in_valid=0. Invalid stage contents must not change outputs.
- Reset mid-operation: in-flight transactions are discarded, never emitted.

Optional Feature:
Macro ZC_NORMALIZE_EN.
- Defined: extra port out_norm out DataWidth. It is the operand shifted by out_count:
  - leading mode: shifted left, zeros in, so the MSB ends up 1;
  - trailing mode: shifted right, zeros in, so the LSB ends up 1.
  - All-zero operand gives out_norm=0.
  - The shift is in stage 2, so latency is unchanged. out_norm holds under stall like the other outputs.
- Undefined: no out_norm port, no operand register in stage 1, no shifter.

Decomposition:
- Package fpu_zc_pkg:
  - typedef zc_mode_e {ZC_TRAILING=0, ZC_LEADING=1};
  - function num_chunks(DataWidth, ChunkWidth);
  - stage-1 payload struct typedef (chunk counts, chunk zero flags, mode, optional operand).
- One sub-module, zc_chunk_counter: combinational count plus all-zero flag for one chunk in either direction. It is instantiated per chunk in stage 1.

Test Plan:
- Trailing, in_data=25'h0000008, mode=0 -> out_count=3, out_zero=0, out_valid exactly 2 cycles later; with ZC_NORMALIZE_EN, out_norm=25'h0000001.
- Leading, in_data=25'h0100000, mode=1 -> out_count=4; with ZC_NORMALIZE_EN, out_norm=25'h1000000. in_data=25'h1FFFFFF -> out_count=0 in both modes.
- in_data=0 in both modes -> out_count=25, out_zero=1, out_norm=0.
- Backpressure: out_ready=0, offer 3 back-to-back inputs -> in_ready drops after 2 accepted. Raising out_ready delivers all 3 in order, no loss or duplication, outputs stable while stalled.
- Reset pulse with 2 transactions in flight -> out_valid=0 immediately, nothing emitted afterwards, next input gives a correct result at latency 2.
- 10000 random operands and modes, random out_ready, ChunkWidth in {1,5,8,25} -> every result matches a bit-loop reference model.
